// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache controller with zero-wait read hits.
// It also keeps saturating hit and miss counters.
module cache_controller #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p_read,
    input  logic                  p_write,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  cache_hit,
    input  logic                  mem_ready,
    output logic                  p_stall,
    output logic                  cache_we,
    output logic                  cache_fill,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_WRITE_MEM = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] w_mem_addr_next;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;
    logic                  w_hit_inc;
    logic                  w_miss_inc;

    // Write wins over a simultaneous read; A is only looked at in IDLE.
    always_comb begin
        w_state_next    = r_state;
        w_mem_addr_next = r_mem_addr;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p_write) begin
                    w_mem_addr_next = A;
                    w_hit_inc       = cache_hit;
                    w_miss_inc      = ~cache_hit;
                    w_state_next    = S_WRITE_MEM;
                end else if (p_read) begin
                    if (cache_hit) begin
                        w_hit_inc = 1'b1;
                    end else begin
                        w_mem_addr_next = {A[ADDR_WIDTH-1:2], 2'b00};
                        w_miss_inc      = 1'b1;
                        w_state_next    = S_FETCH;
                    end
                end
            end
            S_FETCH:     if (mem_ready) w_state_next = S_FILL;
            S_FILL:      w_state_next = S_IDLE;
            S_WRITE_MEM: if (mem_ready) w_state_next = S_DONE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_addr <= w_mem_addr_next;
            if (w_hit_inc && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_ONE;
            end
            if (w_miss_inc && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNT_ONE;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_IDLE:  p_stall = p_write | (p_read & ~cache_hit);
            S_DONE:  p_stall = 1'b0;
            default: p_stall = 1'b1;
        endcase
    end

    // Gated by reset so a held write cannot touch the array while in reset.
    assign cache_we   = reset_n & (r_state == S_IDLE) & p_write & cache_hit;
    assign cache_fill = (r_state == S_FILL);
    assign mem_rd     = (r_state == S_FETCH);
    assign mem_wr     = (r_state == S_WRITE_MEM);
    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
